// File: rtl/fp_add_sequencer.sv
// rtl/fp_add_sequencer.sv - operand-pair FIFO feeding a float adder one Go/Ready op at a time
// Results come back in push order; a missing Ready becomes a quiet-NaN timeout result.
module fp_add_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_a,
  input  logic [31:0]                in_b,
  output logic [31:0]                add_a,
  output logic [31:0]                add_b,
  output logic                       go,
  input  logic [31:0]                add_result,
  input  logic                       add_ready,
  input  logic                       add_zero,
  input  logic                       add_inf,
  input  logic                       add_nan,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic                       out_zero,
  output logic                       out_inf,
  output logic                       out_nan,
  output logic                       out_timeout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t        state, state_nx;
  logic [31:0]   mem_a [DEPTH];
  logic [31:0]   mem_b [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] timer;
  logic          armed;
  logic          push, pop, done, expire, empty, full;

  assign empty    = (count == '0);
  assign full     = (count == FULLC);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    go       = 1'b0;
    pop      = 1'b0;
    done     = 1'b0;
    expire   = 1'b0;
    case (state)
      S_IDLE: if (!empty && !out_valid) begin
        pop      = 1'b1;
        state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        go       = 1'b1;
        state_nx = S_WAIT;
      end
      // Completion wins over expiry when both land on the same edge.
      S_WAIT: if (armed && add_ready) begin
        done     = 1'b1;
        state_nx = S_HOLD;
      end else if (timer == TLAST) begin
        expire   = 1'b1;
        state_nx = S_HOLD;
      end
      S_HOLD: if (out_valid && out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      add_a       <= '0;
      add_b       <= '0;
      timer       <= '0;
      armed       <= 1'b0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_inf     <= 1'b0;
      out_nan     <= 1'b0;
      out_timeout <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (pop) begin
        add_a  <= mem_a[rd_ptr];
        add_b  <= mem_b[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      // armed only after Ready is seen low, so a Ready left high by the previous op is ignored.
      if (go) begin
        timer <= '0;
        armed <= 1'b0;
      end else if (state == S_WAIT) begin
        timer <= timer + TW'(1);
        if (!add_ready) armed <= 1'b1;
      end
      if (done) begin
        out_valid   <= 1'b1;
        out_result  <= add_result;
        out_zero    <= add_zero;
        out_inf     <= add_inf;
        out_nan     <= add_nan;
        out_timeout <= 1'b0;
      end else if (expire) begin
        out_valid   <= 1'b1;
        out_result  <= 32'h7FC0_0000;
        out_zero    <= 1'b0;
        out_inf     <= 1'b0;
        out_nan     <= 1'b1;
        out_timeout <= 1'b1;
      end else if (state == S_HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb/tb_fp_add_sequencer.sv - directed vector bench for fp_add_sequencer with a behavioural adder
module tb_fp_add_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b, add_a, add_b, add_result, out_result;
  logic        go, add_ready, add_zero, add_inf, add_nan;
  logic        out_valid, out_ready, out_zero, out_inf, out_nan, out_timeout, busy;
  logic [2:0]  count;

  fp_add_sequencer #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b), .go(go),
    .add_result(add_result), .add_ready(add_ready), .add_zero(add_zero),
    .add_inf(add_inf), .add_nan(add_nan), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
    .out_inf(out_inf), .out_nan(out_nan), .out_timeout(out_timeout),
    .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b, mres;
    logic        mz, mi, mn;
    int          lat;
    logic [31:0] eres;
    logic        ez, ei, en, et;
    int          elat;
  } vec_t;

  // Adder model modes: 0 fixed result after mlat, 1 never ready, 2 stale-ready, 3 sum after mlat.
  int          mode = 0;
  int          mlat = 2;
  logic [31:0] mres = '0;
  logic        mz = 1'b0, mi = 1'b0, mn = 1'b0;
  int          go_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  always @(negedge clk) if (go) go_cnt++;

  initial begin
    add_ready = 1'b0; add_result = '0; add_zero = 1'b0; add_inf = 1'b0; add_nan = 1'b0;
    forever begin
      @(negedge clk);
      if (go) begin
        if (mode == 2) begin
          add_ready = 1'b1; add_result = 32'hDEAD_BEEF;
          @(negedge clk); @(negedge clk);
          add_ready = 1'b0;
          repeat (3) @(negedge clk);
          add_result = mres; add_zero = mz; add_inf = mi; add_nan = mn; add_ready = 1'b1;
        end else if (mode == 1) begin
          add_ready = 1'b0;
        end else begin
          add_ready = 1'b0;
          repeat (mlat) @(negedge clk);
          add_result = (mode == 3) ? add_a + add_b : mres;
          add_zero = (mode == 3) ? 1'b0 : mz;
          add_inf  = (mode == 3) ? 1'b0 : mi;
          add_nan  = (mode == 3) ? 1'b0 : mn;
          add_ready = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, output logic acc);
    in_a = a; in_b = b; in_valid = 1'b1;
    acc = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts negedges (starting at 1, the push edge already elapsed) until go is seen.
  task automatic wait_go(output int n);
    n = 1;
    while (!go && n < 50) begin @(negedge clk); n++; end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 300) begin @(negedge clk); n++; end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  vec_t        vecs [7];
  logic [31:0] exp_q [$];
  logic        acc, stable, seen;
  int          n, g0, nacc;

  initial begin
    vecs[0] = '{32'h3F800000, 32'h40000000, 32'h40400000, 0, 0, 0, 5,  32'h40400000, 0, 0, 0, 0, 6};
    vecs[1] = '{32'h80000000, 32'h00000000, 32'h00000000, 1, 0, 0, 3,  32'h00000000, 1, 0, 0, 0, 4};
    vecs[2] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 0, 1, 0, 2,  32'h7F800000, 0, 1, 0, 0, 3};
    vecs[3] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 0, 0, 1, 4,  32'h7FC00000, 0, 0, 1, 0, 5};
    vecs[4] = '{32'hC0000000, 32'h40000000, 32'h00000000, 1, 0, 0, 7,  32'h00000000, 1, 0, 0, 0, 8};
    vecs[5] = '{32'h41000000, 32'h40000000, 32'h41200000, 0, 0, 0, 64, 32'h41200000, 0, 0, 0, 0, 65};
    vecs[6] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 0, 0, 0, 65, 32'h7FC00000, 0, 0, 1, 1, 65};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_go", 32'(go), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_add_a", add_a, 0);
    check("rst_out_result", out_result, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("init_in_ready", 32'(in_ready), 1);
    check("init_count", 32'(count), 0);
    check("init_busy", 32'(busy), 0);

    for (int i = 0; i < 7; i++) begin
      mode = 0; mlat = vecs[i].lat; mres = vecs[i].mres;
      mz = vecs[i].mz; mi = vecs[i].mi; mn = vecs[i].mn;
      g0 = go_cnt;
      push_pair(vecs[i].a, vecs[i].b, acc);
      check($sformatf("v%0d_accepted", i), 32'(acc), 1);
      wait_go(n);
      check($sformatf("v%0d_push_to_go", i), n, 2);
      check($sformatf("v%0d_add_a", i), add_a, vecs[i].a);
      wait_valid(n);
      check($sformatf("v%0d_latency", i), n, vecs[i].elat);
      check($sformatf("v%0d_result", i), out_result, vecs[i].eres);
      check($sformatf("v%0d_flags", i), {28'b0, out_zero, out_inf, out_nan, out_timeout},
            {28'b0, vecs[i].ez, vecs[i].ei, vecs[i].en, vecs[i].et});
      check($sformatf("v%0d_go_pulses", i), go_cnt - g0, 1);
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_hold_valid", i), 32'(out_valid), 1);
      accept();
      repeat (4) @(negedge clk);
    end

    // Fill the FIFO while the first result is held unaccepted.
    mode = 3; mlat = 3;
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      push_pair(32'h100 + 32'(i), 32'h2000 + 32'(i * 3), acc);
      if (acc) begin
        nacc++;
        exp_q.push_back(32'h2100 + 32'(i * 4));
      end
    end
    check("fill_accepted", nacc, 5);
    check("fill_count", 32'(count), 4);
    check("fill_in_ready", 32'(in_ready), 0);
    repeat (20) @(negedge clk);
    check("fill_held_valid", 32'(out_valid), 1);
    check("fill_held_count", 32'(count), 4);
    for (int i = 0; i < 5; i++) begin
      wait_valid(n);
      check($sformatf("fill_valid%0d", i), 32'(out_valid), 1);
      check($sformatf("fill_result%0d", i), out_result, exp_q[i]);
      accept();
    end
    repeat (20) @(negedge clk);
    check("fill_drained_count", 32'(count), 0);
    check("fill_no_extra", 32'(out_valid), 0);

    // Stale Ready high across ISSUE must not be taken as completion.
    mode = 2; mres = 32'h3F800000; mz = 1'b0; mi = 1'b0; mn = 1'b0;
    push_pair(32'h3F000000, 32'h3F000000, acc);
    wait_go(n);
    wait_valid(n);
    check("stale_latency", n, 6);
    check("stale_result", out_result, 32'h3F800000);
    accept();
    repeat (3) @(negedge clk);

    // Adder never answers: forced timeout, operands stay put throughout WAIT.
    mode = 1;
    push_pair(32'h40A00000, 32'h40E00000, acc);
    wait_go(n);
    n = 0; stable = 1'b1;
    while (!out_valid && n < 300) begin
      @(negedge clk); n++;
      if (add_a !== 32'h40A00000 || add_b !== 32'h40E00000) stable = 1'b0;
    end
    check("to_latency", n, 65);
    check("to_operands_stable", 32'(stable), 1);
    check("to_result", out_result, 32'h7FC00000);
    check("to_flags", {28'b0, out_zero, out_inf, out_nan, out_timeout}, 32'h3);
    accept();
    repeat (3) @(negedge clk);

    // Reset mid-WAIT with a second pair still queued.
    push_pair(32'h1, 32'h2, acc);
    push_pair(32'h3, 32'h4, acc);
    repeat (10) @(negedge clk);
    check("mid_busy_before", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_go", 32'(go), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_count", 32'(count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_in_ready", 32'(in_ready), 1);
    g0 = go_cnt; seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mid_no_valid", 32'(seen), 0);
    check("mid_no_go", go_cnt - g0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
